// File: rtl/ours_fifo_beat_packer.sv
// Pops narrow FIFO beats and packs RATIO of them into one wide word.
// A ctrl "last" bit or a flush closes the word early with a partial lane mask.
module ours_fifo_beat_packer #(
   parameter int DATA_WIDTH = 32,
   parameter int CTRL_WIDTH = 4,
   parameter int RATIO      = 4,
   parameter int LAST_BIT   = 0
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          fifo_empty,
   output logic                          fifo_re,
   input  logic [DATA_WIDTH-1:0]         fifo_dout,
   input  logic [CTRL_WIDTH-1:0]         fifo_ctrl,
   input  logic                          flush,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [RATIO*DATA_WIDTH-1:0]   out_data,
   output logic [RATIO-1:0]              out_beat_vld,
   output logic [CTRL_WIDTH-1:0]         out_ctrl,
   output logic                          out_last
);

   localparam int IW = $clog2(RATIO);
   localparam int WW = RATIO * DATA_WIDTH;

   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   logic [0:0]    state;
   logic [IW-1:0] idx;
   logic          pop;
   logic          last_beat;
   logic          full_beat;

   assign pop       = rstn & ~fifo_empty & ((state == FILL) | out_ready);
   assign fifo_re   = pop;
   assign last_beat = fifo_ctrl[LAST_BIT];
   assign full_beat = (idx == IW'(RATIO - 1));
   assign out_valid = (state == HOLD);
   assign out_last  = out_ctrl[LAST_BIT];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= FILL;
         idx          <= '0;
         out_data     <= '0;
         out_beat_vld <= '0;
         out_ctrl     <= '0;
      end else if (state == FILL) begin
         if (pop) begin
            out_data[idx*DATA_WIDTH +: DATA_WIDTH] <= fifo_dout;
            out_beat_vld[idx] <= 1'b1;
            out_ctrl          <= fifo_ctrl;
            if (full_beat | last_beat | flush) begin
               state <= HOLD;
               idx   <= '0;
            end else begin
               idx <= idx + 1'b1;
            end
         end else if (flush && (idx != '0)) begin
            state <= HOLD;
            idx   <= '0;
         end
      end else if (out_ready) begin
         // handshake: a beat popped now seeds lane 0 of the next word
         if (pop) begin
            out_data     <= WW'(fifo_dout);
            out_beat_vld <= RATIO'(1);
            out_ctrl     <= fifo_ctrl;
            if (last_beat) begin
               idx <= '0;
            end else begin
               state <= FILL;
               idx   <= IW'(1);
            end
         end else begin
            out_data     <= '0;
            out_beat_vld <= '0;
            state        <= FILL;
            idx          <= '0;
         end
      end
   end

`ifndef SYNTHESIS
   logic [RATIO-1:0] vld_inc;
   assign vld_inc = out_beat_vld + 1'b1;

   a_no_pop_empty: assert property (
      @(posedge clk) !(fifo_re && fifo_empty));

   a_hold_stable: assert property (
      @(posedge clk) disable iff (!rstn)
      (out_valid && !out_ready) |=>
         ($stable(out_data) && $stable(out_beat_vld) && $stable(out_ctrl)));

   a_mask_contig: assert property (
      @(posedge clk) disable iff (!rstn)
      out_valid |-> (out_beat_vld[0] && ((vld_inc & out_beat_vld) == '0)));
`endif

endmodule
